// File: rtl/ecc_pkg.sv
// ecc_pkg: shared SECDED helpers for the ecc_enc / ecc_dec_pipe pair.
//   calculate_m   - number of Hamming check bits needed for k information bits
//   is_pow2       - true for check-bit positions (1, 2, 4, ...)
//   store_dbits   - scatter information bits onto non-power-of-2 positions
//   extract_dbits - gather information bits from non-power-of-2 positions
//   syndrome      - XOR of the positions of all set codeword bits
// Codewords are carried in cw_t with bit index == Hamming position; bit 0 is
// unused here (p0 travels separately). Supports codewords up to MAX_N bits.
package ecc_pkg;

    localparam int MAX_N = 64;

    typedef logic [MAX_N:0]   cw_t;
    typedef logic [MAX_N-1:0] dbits_t;
    typedef logic [7:0]       syn_t;

    // Smallest m with 2^m >= m + k + 1.
    function automatic int calculate_m(input int k);
        int m;
        m = 1;
        while ((1 << m) < m + k + 1) m++;
        return m;
    endfunction

    function automatic bit is_pow2(input int idx);
        return (idx > 0) && ((idx & (idx - 1)) == 0);
    endfunction

    function automatic cw_t store_dbits(input dbits_t data, input int n);
        cw_t cw;
        int  c;
        cw = '0;
        c  = 0;
        for (int p = 1; p <= MAX_N; p++) begin
            if (p <= n && !is_pow2(p)) begin
                cw[p] = data[c];
                c++;
            end
        end
        return cw;
    endfunction

    function automatic dbits_t extract_dbits(input cw_t cw, input int n);
        dbits_t d;
        int     c;
        d = '0;
        c = 0;
        for (int p = 1; p <= MAX_N; p++) begin
            if (p <= n && !is_pow2(p)) begin
                d[c] = cw[p];
                c++;
            end
        end
        return d;
    endfunction

    // Bit i-1 of the result is the parity of all positions with bit i-1 set,
    // which is the same as XOR-ing together the indices of all set bits.
    function automatic syn_t syndrome(input cw_t cw, input int n);
        syn_t s;
        s = '0;
        for (int j = 1; j <= MAX_N; j++) begin
            if (j <= n && cw[j]) s ^= 8'(j);
        end
        return s;
    endfunction

endpackage

// File: rtl/ecc_sat_cnt.sv
// ecc_sat_cnt: saturating event counter.
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   clr           - synchronous clear, wins over inc
//   inc           - count one event this cycle
//   cnt           - current count, sticks at all-ones
module ecc_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ecc_dec_pipe.sv
// ecc_dec_pipe: two-stage pipelined SECDED decoder with valid/ready on both sides.
//   clk_i, rst_ni        - clock, asynchronous active-low reset
//   d_i, valid_i, ready_o - received codeword stream (layout chosen by P0_LSB)
//   q_o, valid_o, ready_i - corrected data stream
//   syndrome_o           - syndrome of the delivered word (0 = none or p0)
//   sb_err_o / db_err_o  - single-bit corrected / uncorrectable error
//   cnt_clr_i            - synchronous clear of both error counters
//   sb_cnt_o / db_cnt_o  - saturating counts of delivered words with each flag
// Stage 1 computes syndrome and overall parity; stage 2 classifies and corrects.
module ecc_dec_pipe
    import ecc_pkg::*;
#(
    parameter int  K      = 8,
    parameter bit  P0_LSB = 1'b1,
    parameter int  CNT_W  = 16,
    localparam int M      = calculate_m(K),
    localparam int N      = M + K
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N:0]       d_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [K-1:0]     q_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [M-1:0]     syndrome_o,
    output logic             sb_err_o,
    output logic             db_err_o,
    input  logic             cnt_clr_i,
    output logic [CNT_W-1:0] sb_cnt_o,
    output logic [CNT_W-1:0] db_cnt_o
);

    localparam logic [M-1:0] N_M = M'(N);

    logic           s1_valid;
    logic [N:1]     s1_cw;
    logic [M-1:0]   s1_syn;
    logic           s1_pchk;
    logic           s1_adv;
    logic           s2_adv;
    logic [N:1]     rx_cw;

    cw_t            dec_cw;
    logic [K-1:0]   dec_q;
    logic           dec_sb;
    logic           dec_db;

    // A stage may load when it is empty or its content moves on this cycle.
    assign s2_adv  = !valid_o || ready_i;
    assign s1_adv  = !s1_valid || s2_adv;
    assign ready_o = s1_adv;

    assign rx_cw = P0_LSB ? d_i[N:1] : d_i[N-1:0];

    // NOTE: data registers are reset too, since the outputs must read as
    // zero after reset, not only the valid bits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_cw    <= '0;
            s1_syn   <= '0;
            s1_pchk  <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= valid_i;
            if (valid_i) begin
                s1_cw   <= rx_cw;
                s1_syn  <= M'(syndrome(cw_t'({rx_cw, 1'b0}), N));
                s1_pchk <= ^d_i;
            end
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        dec_cw = cw_t'({s1_cw, 1'b0});
        dec_sb = 1'b0;
        dec_db = 1'b0;
        if (s1_syn == '0) begin
            // Only p0 can be wrong; data untouched.
            dec_sb = s1_pchk;
        end else if (s1_pchk && (s1_syn <= N_M)) begin
            dec_sb         = 1'b1;
            dec_cw[s1_syn] = ~dec_cw[s1_syn];
        end else begin
            // Even parity with non-zero syndrome, or a position beyond the word.
            dec_db = 1'b1;
        end
        dec_q = K'(extract_dbits(dec_cw, N));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o    <= 1'b0;
            q_o        <= '0;
            syndrome_o <= '0;
            sb_err_o   <= 1'b0;
            db_err_o   <= 1'b0;
        end else if (s2_adv) begin
            valid_o <= s1_valid;
            if (s1_valid) begin
                q_o        <= dec_q;
                syndrome_o <= s1_syn;
                sb_err_o   <= dec_sb;
                db_err_o   <= dec_db;
            end
        end
    end

    ecc_sat_cnt #(.CNT_W(CNT_W)) u_sb_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr    (cnt_clr_i),
        .inc    (valid_o && ready_i && sb_err_o),
        .cnt    (sb_cnt_o)
    );

    ecc_sat_cnt #(.CNT_W(CNT_W)) u_db_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr    (cnt_clr_i),
        .inc    (valid_o && ready_i && db_err_o),
        .cnt    (db_cnt_o)
    );

endmodule

// File: tb/tb_ecc_dec_pipe.sv
// tb_ecc_dec_pipe: self-checking bench for ecc_dec_pipe (K=8, n=12).
// Three instances share the handshake: default layout, a 2-bit-counter copy
// and a p0-at-MSB copy. Expected results come from a Hamming model that
// reasons in terms of which positions were flipped.
module tb_ecc_dec_pipe;

    localparam int N = 12;

    typedef struct packed {
        logic [7:0] q;
        logic [3:0] syn;
        logic       sb;
        logic       db;
    } exp_t;

    typedef struct {
        logic [7:0]  data;
        logic [12:0] flip;
        exp_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [12:0] d_lsb = '0;
    logic [12:0] d_msb;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b0;
    logic        cnt_clr_i = 1'b0;

    logic        rdy_l, rdy_m, rdy_s;
    logic [7:0]  q_l, q_m, q_s;
    logic        val_l, val_m, val_s;
    logic [3:0]  syn_l, syn_m, syn_s;
    logic        sb_l, sb_m, sb_s, db_l, db_m, db_s;
    logic [15:0] sbc_l, dbc_l, sbc_m, dbc_m;
    logic [1:0]  sbc_s, dbc_s;

    assign d_msb = {d_lsb[0], d_lsb[12:1]};

    always #5 clk = ~clk;

    ecc_dec_pipe #(.K(8), .P0_LSB(1'b1), .CNT_W(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .d_i(d_lsb), .valid_i(valid_i), .ready_o(rdy_l),
        .q_o(q_l), .valid_o(val_l), .ready_i(ready_i), .syndrome_o(syn_l),
        .sb_err_o(sb_l), .db_err_o(db_l), .cnt_clr_i(cnt_clr_i),
        .sb_cnt_o(sbc_l), .db_cnt_o(dbc_l));

    ecc_dec_pipe #(.K(8), .P0_LSB(1'b0), .CNT_W(16)) dut_m (
        .clk_i(clk), .rst_ni(rst_n), .d_i(d_msb), .valid_i(valid_i), .ready_o(rdy_m),
        .q_o(q_m), .valid_o(val_m), .ready_i(ready_i), .syndrome_o(syn_m),
        .sb_err_o(sb_m), .db_err_o(db_m), .cnt_clr_i(cnt_clr_i),
        .sb_cnt_o(sbc_m), .db_cnt_o(dbc_m));

    ecc_dec_pipe #(.K(8), .P0_LSB(1'b1), .CNT_W(2)) dut_s (
        .clk_i(clk), .rst_ni(rst_n), .d_i(d_lsb), .valid_i(valid_i), .ready_o(rdy_s),
        .q_o(q_s), .valid_o(val_s), .ready_i(ready_i), .syndrome_o(syn_s),
        .sb_err_o(sb_s), .db_err_o(db_s), .cnt_clr_i(cnt_clr_i),
        .sb_cnt_o(sbc_s), .db_cnt_o(dbc_s));

    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];
    int   xfers = 0;
    int   e_sb16 = 0, e_db16 = 0, e_sb2 = 0, e_db2 = 0;
    bit   stalled = 1'b0;
    exp_t held;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // i-th information bit lives at the i-th position that is not a power of two.
    function automatic int dpos(input int i);
        int c;
        c = 0;
        for (int p = 1; p <= N; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (c == i) return p;
                c++;
            end
        end
        return -1;
    endfunction

    // Encoder: bit j = cw[j], bit 0 = p0 (P0_LSB=1 layout).
    function automatic logic [12:0] enc(input logic [7:0] data);
        logic [12:0] w;
        logic        par;
        w = '0;
        for (int i = 0; i < 8; i++) w[dpos(i)] = data[i];
        for (int b = 0; b < 4; b++) begin
            par = 1'b0;
            for (int j = 1; j <= N; j++) if ((j & (1 << b)) != 0) par ^= w[j];
            w[1 << b] = par;
        end
        w[0] = ^w[12:1];
        return w;
    endfunction

    // Expected result from the set of flipped positions (-1 = unused slot).
    function automatic exp_t model(input logic [7:0] data, input int p1, input int p2);
        exp_t r;
        r.q = data; r.syn = '0; r.sb = 1'b0; r.db = 1'b0;
        if (p1 >= 0 && p2 < 0) begin
            r.syn = 4'(p1);
            r.sb  = 1'b1;
        end else if (p1 >= 0) begin
            r.syn = 4'(p1 ^ p2);
            r.db  = 1'b1;
            for (int i = 0; i < 8; i++)
                if (dpos(i) == p1 || dpos(i) == p2) r.q[i] = ~r.q[i];
        end
        return r;
    endfunction

    // One clock: drive at the falling edge, sample 1 time unit later,
    // update the scoreboard for what the rising edge will do.
    task automatic cycle(input bit v, input logic [12:0] d, input exp_t e,
                         input bit rdy, input bit clr, output bit acc);
        exp_t got_l, got_m, got_s, want;
        bit   have;
        valid_i = v; d_lsb = d; ready_i = rdy; cnt_clr_i = clr;
        #1;
        got_l = {q_l, syn_l, sb_l, db_l};
        got_m = {q_m, syn_m, sb_m, db_m};
        got_s = {q_s, syn_s, sb_s, db_s};
        acc  = v && rdy_l;
        have = 1'b0;
        want = '0;
        if (stalled) begin
            check("hold_valid", 32'(val_l), 32'd1);
            check("hold_out", 32'(got_l), 32'(held));
        end
        if (val_l && rdy) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'(val_l), 32'd0);
            end else begin
                want = exp_q.pop_front();
                have = 1'b1;
                xfers++;
                check("out_lsb", 32'(got_l), 32'(want));
                check("out_msb", 32'({val_m, got_m}), 32'({1'b1, want}));
                check("out_c2", 32'({val_s, got_s}), 32'({1'b1, want}));
            end
        end
        if (clr) begin
            e_sb16 = 0; e_db16 = 0; e_sb2 = 0; e_db2 = 0;
        end else if (have) begin
            if (want.sb) begin
                if (e_sb16 < 65535) e_sb16++;
                if (e_sb2 < 3) e_sb2++;
            end
            if (want.db) begin
                if (e_db16 < 65535) e_db16++;
                if (e_db2 < 3) e_db2++;
            end
        end
        stalled = val_l && !rdy;
        held    = got_l;
        if (acc) exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input bit rdy, input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, rdy, 1'b0, acc);
    endtask

    task automatic check_cnts(input string tag);
        check({tag, "_sbc"}, 32'(sbc_l), 32'(e_sb16));
        check({tag, "_dbc"}, 32'(dbc_l), 32'(e_db16));
        check({tag, "_sbc_msb"}, 32'({sbc_m, dbc_m}), 32'({16'(e_sb16), 16'(e_db16)}));
        check({tag, "_c2"}, 32'({sbc_s, dbc_s}), 32'({2'(e_sb2), 2'(e_db2)}));
    endtask

    task automatic do_reset();
        valid_i = 1'b0; ready_i = 1'b0; cnt_clr_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_valid", 32'({val_l, val_m, val_s}), 32'd0);
        check("rst_out", 32'({q_l, syn_l, sb_l, db_l}), 32'd0);
        check("rst_cnt", 32'({sbc_l, dbc_l}), 32'd0);
        check("rst_cnt_c2", 32'({sbc_s, dbc_s}), 32'd0);
        check("rst_ready", 32'({rdy_l, rdy_m, rdy_s}), 32'h7);
        exp_q.delete();
        e_sb16 = 0; e_db16 = 0; e_sb2 = 0; e_db2 = 0;
        stalled = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t vecs[8];

    initial begin
        bit          acc;
        int          n0, idx, p1, p2, nerr;
        logic [7:0]  data;
        logic [12:0] flip;

        vecs[0] = '{8'hA5, 13'h0000,              '{8'hA5, 4'd0,  1'b0, 1'b0}};
        vecs[1] = '{8'hA5, 13'h0020,              '{8'hA5, 4'd5,  1'b1, 1'b0}};
        vecs[2] = '{8'h3C, 13'h0001,              '{8'h3C, 4'd0,  1'b1, 1'b0}};
        vecs[3] = '{8'hA5, 13'h0048,              '{8'hA0, 4'd5,  1'b0, 1'b1}};
        vecs[4] = '{8'hFF, 13'h1000,              '{8'hFF, 4'd12, 1'b1, 1'b0}};
        vecs[5] = '{8'h00, 13'h0010,              '{8'h00, 4'd4,  1'b1, 1'b0}};
        vecs[6] = '{8'h00, 13'h1002,              '{8'h80, 4'd13, 1'b0, 1'b1}};
        vecs[7] = '{8'h55, 13'h0081,              '{8'h5D, 4'd7,  1'b0, 1'b1}};

        @(negedge clk);
        do_reset();

        // Directed vectors, one at a time, with a 2-cycle latency check.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, enc(vecs[i].data) ^ vecs[i].flip, vecs[i].exp, 1'b1, 1'b0, acc);
            check($sformatf("vec%0d_accept", i), 32'(acc), 32'd1);
            n0 = xfers;
            idle(1'b1, 1);
            check($sformatf("vec%0d_lat1", i), 32'(xfers - n0), 32'd0);
            idle(1'b1, 1);
            check($sformatf("vec%0d_lat2", i), 32'(xfers - n0), 32'd1);
            check_cnts($sformatf("vec%0d", i));
        end

        // Backpressure: 8 clean words, downstream stalled for the first 5 cycles.
        idx = 0;
        n0  = xfers;
        for (int c = 0; c < 40; c++) begin
            cycle(idx < 8, enc(8'(idx)), model(8'(idx), -1, -1), c >= 5, 1'b0, acc);
            if (acc) idx++;
            if (c == 4) check("bp_accepted_while_stalled", 32'(idx), 32'd2);
        end
        check("bp_all_accepted", 32'(idx), 32'd8);
        check("bp_all_delivered", 32'(xfers - n0), 32'd8);

        // Randomized traffic with 0, 1 or 2 flipped bits.
        for (int c = 0; c < 600; c++) begin
            data = 8'($urandom);
            nerr = int'($urandom_range(0, 2));
            p1 = -1; p2 = -1; flip = '0;
            if (nerr >= 1) begin
                p1 = int'($urandom_range(0, N));
                flip = 13'b1 << p1;
            end
            if (nerr == 2) begin
                do p2 = int'($urandom_range(0, N)); while (p2 == p1);
                flip = flip | (13'b1 << p2);
            end
            cycle($urandom_range(0, 3) != 0, enc(data) ^ flip, model(data, p1, p2),
                  $urandom_range(0, 3) != 0, 1'b0, acc);
        end
        idle(1'b1, 6);
        check("rand_drained", 32'(exp_q.size()), 32'd0);
        check_cnts("rand");

        // Counter saturation and clear priority.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            data = 8'($urandom);
            p1 = int'($urandom_range(0, N));
            cycle(1'b1, enc(data) ^ (13'b1 << p1), model(data, p1, -1), 1'b1, 1'b0, acc);
        end
        idle(1'b1, 3);
        check("c2_saturated", 32'(sbc_s), 32'd3);
        check("c16_five", 32'(sbc_l), 32'd5);
        check_cnts("sat");
        cycle(1'b1, enc(8'h11) ^ 13'h0200, model(8'h11, 9, -1), 1'b1, 1'b0, acc);
        n0 = xfers;
        idle(1'b1, 1);
        cycle(1'b0, '0, '0, 1'b1, 1'b1, acc);
        check("clr_same_cycle_xfer", 32'(xfers - n0), 32'd1);
        check("clr_wins", 32'({sbc_l, sbc_s}), 32'd0);
        check_cnts("clr");

        // Reset with words in flight.
        cycle(1'b1, enc(8'h22) ^ 13'h0001, model(8'h22, 0, -1), 1'b1, 1'b0, acc);
        idle(1'b1, 3);
        check_cnts("pre_rst");
        for (int i = 0; i < 3; i++)
            cycle(1'b1, enc(8'(i + 8'h40)), model(8'(i + 8'h40), -1, -1), 1'b0, 1'b0, acc);
        do_reset();
        idle(1'b1, 6);
        cycle(1'b1, enc(8'hA5), model(8'hA5, -1, -1), 1'b1, 1'b0, acc);
        idle(1'b1, 3);
        check("post_rst_drained", 32'(exp_q.size()), 32'd0);
        check_cnts("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
